// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Holds op field layout, size and response codes, and FSM states.
package lsu_pkg;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int OP_SZ_HI = 1;
  localparam int OP_SZ_LO = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FAULT    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_WAIT_R = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  // Illegal size wins over misalignment, which wins over range.
  function automatic err_e req_err(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [31:0] limit
  );
    size_e sz;
    sz = size_e'(op[OP_SZ_HI:OP_SZ_LO]);
    if (sz == SZ_ILL)
      return ERR_ILLEGAL;
    if ((sz == SZ_HALF && addr[0]) ||
        (sz == SZ_WORD && addr[1:0] != 2'b00))
      return ERR_MISALIGN;
    if (addr >= limit)
      return ERR_FAULT;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select/extend for loads.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  size_e       size;
  logic        sx;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    size    = size_e'(op_i[OP_SZ_HI:OP_SZ_LO]);
    sx      = ~op_i[OP_UNS];
    lane_b  = rdata_i[8*addr_lo_i +: 8];
    lane_h  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    unique case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sx & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sx & lane_h[15]}}, lane_h};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with req/gnt/rvalid memory port.
// All outputs except req_ready are registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic [3:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  err_e        resp_err_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [29:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic        idle;
  err_e        acc_err;
  logic [3:0]  al_op;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign idle    = (state_q == S_IDLE);
  assign acc_err = req_err(req_op, req_addr, ADDR_LIMIT);

  // Aligner sees the live request while idle, the held op afterwards.
  assign al_op = idle ? req_op : op_q;
  assign al_lo = idle ? req_addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .op_i      (al_op),
    .addr_lo_i (al_lo),
    .wdata_i   (req_wdata),
    .rdata_i   (mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_lo_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_lo_q <= req_addr[1:0];
            if (acc_err != ERR_OK) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= acc_err;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= S_ISSUE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_op[OP_STORE];
              mem_addr_q  <= req_addr[31:2];
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end
          end
        end
        S_ISSUE: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (op_q[OP_STORE]) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ERR_OK;
              resp_rdata_q <= '0;
            end else begin
              state_q <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_OK;
            resp_rdata_q <= al_rdata;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          resp_err_q   <= ERR_OK;
          resp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = idle;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_ILL = 4'b0011;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, " mem_addr"}, {2'd0, mem_addr}, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, " resp_err"}, {30'd0, resp_err}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] e_be, input logic [31:0] e_wd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd1);
    chk({tag, " mem_addr"}, {2'd0, mem_addr}, addr >> 2);
    chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, e_be});
    chk({tag, " mem_wdata"}, mem_wdata, e_wd);
    chk({tag, " early resp"}, {31'd0, resp_valid}, 32'd0);
    tick();
    mem_gnt = 1'b0;
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " resp_err"}, {30'd0, resp_err}, 32'd0);
    chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, " mem_req off"}, {31'd0, mem_req}, 32'd0);
    tick();
    chk({tag, " resp pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " ready back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] rd,
                         input logic [3:0] e_be, input logic [31:0] e_rd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, e_be});
    // rvalid with gnt must be ignored; its data is a decoy.
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    chk({tag, " wait resp"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " req dropped"}, {31'd0, mem_req}, 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " rdata"}, resp_rdata, e_rd);
    chk({tag, " err"}, {30'd0, resp_err}, 32'd0);
    tick();
    chk({tag, " resp pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic [3:0] op,
                        input logic [31:0] addr, input logic [1:0] e_err);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = 32'hFFFF_FFFF;
    mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, " no mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " err"}, {30'd0, resp_err}, {30'd0, e_err});
    chk({tag, " rdata"}, resp_rdata, 32'd0);
    chk({tag, " not ready"}, {31'd0, req_ready}, 32'd0);
    tick();
    mem_gnt = 1'b0;
    chk({tag, " resp pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " no mem_req2"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0;
    req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    // Reset must dominate a concurrent request.
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h10;
    tick();
    chk_idle_outs("reset");
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk_idle_outs("post reset");

    do_store("sw", OP_SW, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb", OP_SB, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", OP_SH, 32'h12, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    do_store("sb edge", OP_SB, 32'h2FFF, 32'h0000_0077, 4'b1000,
             32'h7777_7777);

    do_load("lb1", OP_LB, 32'h1, 32'h80FF_7F01, 4'b0010, 32'h0000_007F);
    do_load("lb2", OP_LB, 32'h2, 32'h80FF_7F01, 4'b0100, 32'hFFFF_FFFF);
    do_load("lbu3", OP_LBU, 32'h3, 32'h80FF_7F01, 4'b1000, 32'h0000_0080);
    do_load("lh2", OP_LH, 32'h2, 32'h80FF_7F01, 4'b1100, 32'hFFFF_80FF);
    do_load("lhu2", OP_LHU, 32'h2, 32'h80FF_7F01, 4'b1100, 32'h0000_80FF);
    do_load("lh0", OP_LH, 32'h0, 32'h80FF_7F01, 4'b0011, 32'h0000_7F01);
    do_load("lw0", OP_LW, 32'h0, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01);

    do_err("lw mis", OP_LW, 32'h6, 2'b01);
    do_err("lh mis", OP_LH, 32'h3, 2'b01);
    do_err("lw fault", OP_LW, 32'h3000, 2'b10);
    do_err("ill", OP_ILL, 32'h3001, 2'b11);
    do_err("s ill", 4'b1111, 32'h0, 2'b11);

    // Stalled load; a second request is presented and must be ignored.
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h20;
    tick();
    req_op = OP_SB; req_addr = 32'h44; req_wdata = 32'h11;
    for (int i = 0; i < 5; i++) begin
      chk("stall mem_req", {31'd0, mem_req}, 32'd1);
      chk("stall addr", {2'd0, mem_addr}, 32'h8);
      chk("stall be", {28'd0, mem_be}, 32'hF);
      chk("stall we", {31'd0, mem_we}, 32'd0);
      chk("stall ready", {31'd0, req_ready}, 32'd0);
      chk("stall resp", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rwait req", {31'd0, mem_req}, 32'd0);
      chk("rwait ready", {31'd0, req_ready}, 32'd0);
      chk("rwait resp", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    req_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("stall resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("stall rdata", resp_rdata, 32'hCAFE_F00D);
    tick();
    chk("stall pulse", {31'd0, resp_valid}, 32'd0);
    chk("stall ready", {31'd0, req_ready}, 32'd1);
    chk("stall no reissue", {31'd0, mem_req}, 32'd0);

    // Reset while waiting for read data.
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h40;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    reset = 1'b0; mem_rvalid = 1'b0;
    chk_idle_outs("mid reset");
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("late rvalid resp", {31'd0, resp_valid}, 32'd0);
    chk("late rvalid ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("late rvalid resp2", {31'd0, resp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 32'h0000_3000; byte addresses >= ADDR_LIMIT are access faults.
REQ-002 SHALL have ports, in this order:
 clk  in  1  clock; all state updates on rising edge
 reset  in  1  reset, synchronous, active-high
 req_valid  in  1  pipeline request present
 req_ready  out  1  unit can accept request (high only in IDLE)
 req_op  in  4  {store, unsigned, size[1:0]}; size 00 byte, 01 half, 10 word, 11 illegal
 req_addr  in  32  byte address
 req_wdata  in  32  store data, right-aligned
 resp_valid  out  1  one-cycle completion pulse
 resp_rdata  out  32  extended load data; 0 for stores and errors
 resp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal op
 mem_req  out  1  memory request, held until granted
 mem_gnt  in  1  memory accepted request this cycle
 mem_we  out  1  1 = write
 mem_addr  out  30  word address (req_addr[31:2])
 mem_be  out  4  byte enables
 mem_wdata  out  32  lane-steered write data
 mem_rvalid  in  1  read data valid
 mem_rdata  in  32  raw word read data

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, WAIT_R, DONE.
REQ-004 SHALL accept only when req_valid && req_ready in IDLE, registering op, addr, wdata.
REQ-005 On accept, SHALL check in priority order: size 11 -> err 11; half with addr[0]=1 or word with addr[1:0]!=0 -> err 01; addr >= ADDR_LIMIT -> err 10.
REQ-006 On any error SHALL go IDLE->DONE with no mem_req assertion; otherwise IDLE->ISSUE.
REQ-007 In ISSUE SHALL assert mem_req with mem_addr/mem_we/mem_be/mem_wdata stable until mem_gnt.
REQ-008 On mem_gnt SHALL go ISSUE->DONE for stores, ISSUE->WAIT_R for loads; mem_rvalid in the gnt cycle SHALL be ignored.
REQ-009 In WAIT_R SHALL capture mem_rdata on mem_rvalid and go to DONE; waiting unbounded.
REQ-010 In DONE SHALL assert resp_valid exactly one cycle, then return to IDLE; resp_rdata/resp_err valid only with resp_valid.
REQ-011 mem_be SHALL be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111 (loads and stores).
REQ-012 mem_wdata SHALL replicate byte x4 for byte, half x2 for half, pass word unchanged.
REQ-013 Loads SHALL select lane by addr[1:0] (byte) or addr[1] (half), sign-extend unless unsigned bit set; unsigned bit ignored for words and stores.
REQ-014 Minimum latency: store 2 cycles accept->resp_valid with immediate gnt; load 3 cycles with gnt immediate and rvalid next cycle; error 1 cycle.
REQ-015 req_valid while not in IDLE SHALL be ignored (no queuing).
REQ-016 mem_gnt or mem_rvalid in states not waiting for them SHALL be ignored.

Reset
REQ-017 On reset SHALL enter IDLE; req_ready 1 after reset; mem_req, mem_we, resp_valid 0; mem_be, mem_addr, mem_wdata, resp_rdata, resp_err all 0.
REQ-018 Reset mid-operation SHALL abandon the transaction without resp_valid; reset dominates concurrent req_valid, mem_gnt, mem_rvalid.

Structure
REQ-019 Package lsu_pkg SHALL hold op field positions, size codes, resp_err codes and the FSM state enum.
REQ-020 Lane steering and load extension SHALL be a combinational sub-module lsu_align; FSM and registers in load_store_unit.

Verification
REQ-021 sw addr 0x10 data 0xDEADBEEF, gnt immediate -> mem_addr 0x4, be 1111, wdata 0xDEADBEEF, resp_valid 2 cycles after accept, err 00.
REQ-022 sb addr 0x13 data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5; sh addr 0x12 data 0x1234 -> be 1100, wdata 0x12341234.
REQ-023 mem_rdata 0x80FF7F01: lb @0x1 -> 0x0000007F; lb @0x2 -> 0xFFFFFFFF; lbu @0x3 -> 0x00000080; lh @0x2 -> 0xFFFF80FF; lhu @0x2 -> 0x000080FF.
REQ-024 lw @0x6 -> err 01; lw @0x3000 -> err 10; op size 11 -> err 11; each: no mem_req, resp_valid 1 cycle after accept.
REQ-025 gnt withheld 5 cycles then rvalid after 3 more -> mem outputs stable, req_ready 0 throughout, single resp_valid.
REQ-026 reset asserted in WAIT_R -> next cycle IDLE, all outputs at reset values, no resp_valid; later rvalid ignored.
